rail_fence_encrypt: RTL

//  Rail-fence (zigzag) encryptor; the transmit-side counterpart of rail_fence decryption.

---
 rtl/rail_fence_encrypt_pkg.sv | 14 +
 rtl/rail_zigzag_counter.sv | 48 ++++
 rtl/rail_fence_encrypt.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rail_fence_encrypt_pkg.sv
// Shared definitions for the rail-fence encryptor: FSM state encoding and default widths.
package rail_fence_encrypt_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_MAX_LEN = 32;
  localparam int RF_KEY_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } rf_state_e;

endpackage

// File: rtl/rail_zigzag_counter.sv
// Zigzag rail tracker: walks 0,1..K-1,K-2..1,0,... one step per enable; clr restarts at rail 0 going down.
module rail_zigzag_counter #(
  parameter int KEY_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [KEY_W-1:0] k,
  output logic [KEY_W-1:0] rail
);

  logic [KEY_W-1:0] rail_r;
  logic             dir_up_r;

  // Rail position and direction; the direction turns at rail K-1 and at rail 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rail_r   <= '0;
      dir_up_r <= 1'b0;
    end else if (clr) begin
      rail_r   <= '0;
      dir_up_r <= 1'b0;
    end else if (en) begin
      if (k <= KEY_W'(1)) begin
        rail_r   <= '0;
        dir_up_r <= 1'b0;
      end else if (!dir_up_r) begin
        if (rail_r == k - KEY_W'(1)) begin
          rail_r   <= rail_r - KEY_W'(1);
          dir_up_r <= 1'b1;
        end else begin
          rail_r <= rail_r + KEY_W'(1);
        end
      end else begin
        if (rail_r == '0) begin
          rail_r   <= rail_r + KEY_W'(1);
          dir_up_r <= 1'b0;
        end else begin
          rail_r <= rail_r - KEY_W'(1);
        end
      end
    end
  end

  assign rail = rail_r;

endmodule

// File: rtl/rail_fence_encrypt.sv
// Rail-fence encryptor: buffers one plaintext message, then streams the ciphertext rail by rail
// through a one-deep registered output stage.
module rail_fence_encrypt
  import rail_fence_encrypt_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int MAX_LEN = RF_MAX_LEN,
  parameter int KEY_W   = RF_KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = PTR_W + 1;

  rf_state_e         state_r;
  logic [DATA_W-1:0] buf_r [MAX_LEN];
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued_r;
  logic [PTR_W-1:0]  pos_r;
  logic [KEY_W-1:0]  pass_r;
  logic [KEY_W-1:0]  k_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic              busy_r;

  logic              in_fire_s;
  logic              out_fire_s;
  logic              scan_s;
  logic              hit_s;
  logic              wrap_s;
  logic              zz_clr_s;
  logic [PTR_W-1:0]  wr_idx_s;
  logic [KEY_W-1:0]  rail_s;

  // Handshakes and scan control; the scan pauses while a presented char is stalled.
  always_comb begin
    in_fire_s  = in_valid && in_ready_r;
    out_fire_s = out_valid_r && out_ready;
    scan_s     = 1'b0;
    hit_s      = 1'b0;
    wrap_s     = 1'b0;
    if ((state_r == EMIT) && !(out_valid_r && !out_ready) && (issued_r != len_r)) begin
      scan_s = 1'b1;
      hit_s  = (rail_s == pass_r);
      wrap_s = (LEN_W'(pos_r) == len_r - LEN_W'(1));
    end else begin
      scan_s = 1'b0;
    end
    zz_clr_s = (state_r != EMIT) || wrap_s;
    if (state_r == IDLE) begin
      wr_idx_s = '0;
    end else begin
      wr_idx_s = len_r[PTR_W-1:0];
    end
  end

  rail_zigzag_counter #(
    .KEY_W(KEY_W)
  ) u_zigzag (
    .clk (clk),
    .rst (rst),
    .clr (zz_clr_s),
    .en  (scan_s),
    .k   (k_r),
    .rail(rail_s)
  );

  // Message storage; contents are only meaningful below len_r, so no reset.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      buf_r[wr_idx_s] <= in_data;
    end
  end

  // Main FSM with registered handshake and output signals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= '0;
      issued_r    <= '0;
      pos_r       <= '0;
      pass_r      <= '0;
      k_r         <= KEY_W'(1);
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          issued_r <= '0;
          pos_r    <= '0;
          pass_r   <= '0;
          if (in_fire_s) begin
            k_r    <= (key < KEY_W'(2)) ? KEY_W'(1) : key;
            len_r  <= LEN_W'(1);
            busy_r <= 1'b1;
            if (in_last) begin
              state_r    <= EMIT;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_fire_s) begin
            len_r <= len_r + LEN_W'(1);
            // The MAX_LEN-th char closes the message even without in_last.
            if (in_last || (len_r == LEN_W'(MAX_LEN - 1))) begin
              state_r    <= EMIT;
              in_ready_r <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (hit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= buf_r[pos_r];
            out_last_r  <= (issued_r + LEN_W'(1) == len_r);
            issued_r    <= issued_r + LEN_W'(1);
          end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
          if (scan_s) begin
            if (wrap_s) begin
              pos_r  <= '0;
              pass_r <= pass_r + KEY_W'(1);
            end else begin
              pos_r <= pos_r + PTR_W'(1);
            end
          end
          if (out_fire_s && out_last_r) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

endmodule
